sram_controller: RTL
====================

// Module: sram_controller
// PURPOSE
//  Initiator side of the external 64-bit SRAM interface. Sits between the MEM stage
//  and the SRAM device. Turns 32-bit byte-addressed read/write requests into SRAM cycles.
//  Holds 'ready' low for the fixed access time, which stalls the pipeline.
//  A read returns the full 64-bit even/odd word pair for the cache line fill.
// PARAMETERS
//  ADDR_BASE    1024  byte address mapped to SRAM word 0
//  WAIT_CYCLES  5     clk cycles an access is held on the bus (>= ceil(30ns/Tclk)+1)
//  SRAM_AW      17    SRAM word-address width
// PORTS
//  clk         in     1        system clock, rising edge
//  rst         in     1        reset, asynchronous, active-high
//  wr_en       in     1        write request, held until ready=1
//  rd_en       in     1        read request, held until ready=1
//  address     in     32       byte address of request
//  write_data  in     32       word to write
//  read_data   out    64       {word[odd], word[even]} of last completed read
//  ready       out    1        0 = stall requester; 1 = no request pending or access done
//  SRAM_WE_N   out    1        SRAM write enable, active-low
//  SRAM_ADDR   out    SRAM_AW  SRAM word address
//  SRAM_DQ     inout  64       data bus; driven only while SRAM_WE_N=0, else 'z
// BEHAVIOUR
//  - Reset values: FSM state IDLE, counter 0, SRAM_WE_N=1, SRAM_ADDR=0, SRAM_DQ='z,
//    read_data=0. Reset mid-access aborts at once: WE_N returns high asynchronously.
//  - Address map: word = (address - ADDR_BASE) >> 2, truncated to SRAM_AW bits.
//    Addresses outside the window wrap modulo 2^SRAM_AW. No error is flagged.
//    Address and data are registered at acceptance and held stable for the whole access.
//  - FSM states: IDLE, READ, WRITE, DONE.
//    IDLE -> WRITE if wr_en. Otherwise IDLE -> READ if rd_en. wr_en has priority when
//    both are asserted. WRITE/READ -> DONE once the counter reaches WAIT_CYCLES-1.
//    DONE -> IDLE unconditionally.
//  - Counter: cleared on acceptance, increments by 1 each cycle in READ/WRITE.
//  - ready (combinational):
//    = 1 in DONE.
//    = 0 in READ/WRITE.
//    = 0 in IDLE while (rd_en|wr_en).
//    = 1 in IDLE with no request.
//    A request sees ready=0 for WAIT_CYCLES+1 cycles, then ready=1 for exactly one cycle.
//  - WRITE: SRAM_WE_N=0 and SRAM_DQ={32'b0, wdata_reg} for every WRITE-state cycle.
//    The device writes DQ[31:0] to SRAM_ADDR.
//  - READ: SRAM_WE_N=1 and the bus is released. read_data <= SRAM_DQ on the READ->DONE edge.
//    read_data then holds until the next read completes. Writes never modify read_data.
//  - A request still asserted in DONE is not re-accepted. It is re-accepted in the
//    following IDLE cycle, so back-to-back accesses cost WAIT_CYCLES+2 cycles each.
//  - A request dropped during READ/WRITE does not cancel the access; it completes normally.
//  - No bus contention: DQ is driven only while WE_N=0, in the same state that drives WE_N.
// STRUCTURE
//  - Shared package: state encoding (IDLE/READ/WRITE/DONE), ADDR_BASE default,
//    SRAM_AW, SRAM data width 64.
//  - One sub-module, sram_wait_counter:
//    inputs clear/enable; output 'last' when count == WAIT_CYCLES-1.
//  - The top level holds the FSM, the address/data registers, the read_data register
//    and the tri-state driver.
// TESTING
//  - Reset: rst pulse -> WE_N=1, DQ='z, read_data=0, ready=1 with no request pending.
//  - Write: wr_en, address=1032, data=0xDEADBEEF ->
//    SRAM_ADDR=2 and WE_N=0 for 5 cycles, ready=0 for 6 cycles then 1.
//    A later read of 1032 returns read_data[31:0]=0xDEADBEEF.
//  - Read of a preset pair: rd_en, address=1028 (word 1) ->
//    read_data={mem[1],mem[0]}=64'h00000001_00000000 on the ready=1 cycle.
//  - Simultaneous rd_en & wr_en -> write is performed (WE_N=0 seen); read_data unchanged.
//  - Back-to-back reads of 1024 and 1040 with requests held ->
//    two ready=1 pulses 7 cycles apart; each read_data is correct.
//  - rst asserted during the 3rd WRITE cycle -> WE_N=1 within the same cycle,
//    DQ='z, FSM in IDLE after reset releases.

Source files
------------

// File: rtl/sram_controller_pkg.sv
// Shared definitions for the external 64-bit SRAM initiator: state encoding,
// default geometry and the byte-to-word address mapping.
package sram_controller_pkg;

  localparam int unsigned SRAM_DW             = 64;
  localparam int unsigned SRAM_AW_DEFAULT     = 17;
  localparam int unsigned ADDR_BASE_DEFAULT   = 1024;
  localparam int unsigned WAIT_CYCLES_DEFAULT = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } sram_state_e;

  // Full-width word offset; the caller truncates to its SRAM address width,
  // which makes out-of-window addresses wrap.
  function automatic logic [31:0] byte_to_word(input logic [31:0] addr,
                                               input logic [31:0] base);
    return (addr - base) >> 2;
  endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Access-time counter: cleared when a request is accepted, advanced while the
// access is on the bus, flags the final cycle of the access window.
module sram_wait_counter #(
  parameter int unsigned WAIT_CYCLES = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic last_o
);

  localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign last_o = (count_q == CW'(WAIT_CYCLES - 1));

endmodule

// File: rtl/sram_controller.sv
// Initiator for the external 64-bit SRAM: turns byte-addressed MEM-stage
// requests into fixed-length SRAM cycles, stalling the requester via ready.
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int unsigned ADDR_BASE   = ADDR_BASE_DEFAULT,
  parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEFAULT,
  parameter int unsigned SRAM_AW     = SRAM_AW_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic                rd_en,
  input  logic [31:0]         address,
  input  logic [31:0]         write_data,
  output logic [SRAM_DW-1:0]  read_data,
  output logic                ready,
  output logic                SRAM_WE_N,
  output logic [SRAM_AW-1:0]  SRAM_ADDR,
  inout  wire  [SRAM_DW-1:0]  SRAM_DQ
);

  sram_state_e        state_q, state_d;
  logic [SRAM_AW-1:0] addr_q;
  logic [31:0]        wdata_q;
  logic [SRAM_DW-1:0] rdata_q;

  logic accept;
  logic accept_wr;
  logic capture;
  logic cnt_en;
  logic cnt_last;
  logic drive_bus;

  sram_wait_counter #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait (
    .clk     (clk),
    .rst     (rst),
    .clear_i (accept),
    .enable_i(cnt_en),
    .last_o  (cnt_last)
  );

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    accept_wr = 1'b0;
    capture   = 1'b0;
    cnt_en    = 1'b0;
    ready     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready = !(rd_en || wr_en);
        if (wr_en) begin
          state_d   = ST_WRITE;
          accept    = 1'b1;
          accept_wr = 1'b1;
        end else if (rd_en) begin
          state_d = ST_READ;
          accept  = 1'b1;
        end
      end
      ST_READ: begin
        cnt_en = 1'b1;
        if (cnt_last) begin
          state_d = ST_DONE;
          capture = 1'b1;
        end
      end
      ST_WRITE: begin
        cnt_en = 1'b1;
        if (cnt_last) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // A request still held here is picked up again only in the next IDLE.
        ready   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        addr_q <= SRAM_AW'(byte_to_word(address, 32'(ADDR_BASE)));
      end
      if (accept_wr) begin
        wdata_q <= write_data;
      end
      if (capture) begin
        rdata_q <= SRAM_DQ;
      end
    end
  end

  // WE_N and the DQ driver share one decode of the registered state, so reset
  // releases both asynchronously and they can never disagree.
  assign drive_bus = (state_q == ST_WRITE);
  assign SRAM_WE_N = !drive_bus;
  assign SRAM_DQ   = drive_bus ? {32'b0, wdata_q} : 'z;
  assign SRAM_ADDR = addr_q;
  assign read_data = rdata_q;

endmodule
